// File: rtl/taylor_cos_horner_param.sv
// taylor_cos_horner_param: iterative Horner-form Taylor cosine, one shared multiplier; define TAYLOR_SIN_EN to add sin_out
module taylor_cos_horner_param #(
  parameter int W = 24,
  parameter int FRAC = 10,
  parameter int TERMS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic signed [W-1:0] angle_in,
  output logic                ready,
  output logic                valid,
  output logic signed [W-1:0] cos_out
`ifdef TAYLOR_SIN_EN
  ,
  output logic signed [W-1:0] sin_out
`endif
);
  typedef enum logic [2:0] {IDLE, SQUARE, MULC, MULACC, DONE} state_t;
  localparam logic signed [W+1:0] ONE = (W+2)'(2 ** FRAC);
  function automatic logic signed [W+1:0] coef(input int k, input int off);
    int den;
    den = (2 * k - 1 + off) * (2 * k + off) + (k == 0 ? 1 : 0);
    return k == 0 ? '0 : (W+2)'((2 ** FRAC + den / 2) / den);
  endfunction
  function automatic logic signed [W-1:0] sat(input logic signed [W+1:0] v);
    logic signed [W+1:0] r;
    r = v > ONE ? ONE : (v < -ONE ? -ONE : v);
    return (W)'(r);
  endfunction
  state_t state;
  logic [2:0] k;
  logic signed [W-1:0] angle;
  logic signed [W+1:0] x2, t, acc, ma, mb, mq;
  logic signed [2*W-1:0] mp;
  logic signed [W+1:0] c_tab [8];
  for (genvar i = 0; i < 8; i++) begin : g_c
    assign c_tab[i] = coef(i, 0);
  end
  // shared multiplier: angle^2 in SQUARE, x2*c_k in MULC, t*acc in MULACC
  always_comb begin
    ma = state == MULC ? x2 : (state == MULACC ? t : (W+2)'(angle));
    mb = state == MULC ? c_tab[k] : (state == MULACC ? acc : (W+2)'(angle));
    mp = (2*W)'(ma) * (2*W)'(mb);
    mq = (W+2)'(mp >>> FRAC);
  end
  // control FSM and cosine datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      valid   <= 1'b0;
      cos_out <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          angle <= angle_in;
          ready <= 1'b0;
          state <= SQUARE;
        end
        SQUARE: begin
          x2    <= mq;
          acc   <= ONE;
          k     <= 3'(TERMS - 1);
          state <= TERMS == 1 ? DONE : MULC;
        end
        MULC: begin
          t     <= mq;
          state <= MULACC;
        end
        MULACC: begin
          acc   <= ONE - mq;
          k     <= k - 3'd1;
          state <= k == 3'd1 ? DONE : MULC;
        end
        DONE: begin
          cos_out <= sat(acc);
          valid   <= 1'b1;
          ready   <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TAYLOR_SIN_EN
  logic signed [W+1:0] ts, acc_s, sa, sb, sq;
  logic signed [2*W-1:0] sp;
  logic signed [W+1:0] d_tab [8];
  for (genvar i = 0; i < 8; i++) begin : g_d
    assign d_tab[i] = coef(i, 1);
  end
  // sine multiplier: x2*d_k in MULC, ts*acc_s in MULACC, angle*acc_s in DONE
  always_comb begin
    sa = state == MULC ? x2 : (state == MULACC ? ts : (W+2)'(angle));
    sb = state == MULC ? d_tab[k] : acc_s;
    sp = (2*W)'(sa) * (2*W)'(sb);
    sq = (W+2)'(sp >>> FRAC);
  end
  // sine accumulator stepped in lockstep with the cosine one
  always_ff @(posedge clock) begin
    if (reset) sin_out <= '0;
    else if (state == SQUARE) acc_s <= ONE;
    else if (state == MULC) ts <= sq;
    else if (state == MULACC) acc_s <= ONE - sq;
    else if (state == DONE) sin_out <= sat(sq);
  end
`endif
endmodule
